// File: rtl/move_scheduler_if.sv
// Command handshake between the move scheduler and the game FSM.
// The scheduler (master) offers one move per valid/ready handshake.
interface move_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/move_scheduler.sv
// Timing and arbitration front-end for the game FSM's move_block step.
// Generates gravity ticks, auto-repeats held left/right keys, merges all
// move requests onto one valid/ready command port and tracks lines/level.
module move_scheduler #(
  parameter int BASE_PERIOD     = 25_000_000,
  parameter int PERIOD_STEP     = 2_000_000,
  parameter int MIN_PERIOD      = 2_500_000,
  parameter int DAS_DELAY       = 8_000_000,
  parameter int DAS_REPEAT      = 2_500_000,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             game_over,
  input  logic [7:0]       keycode,
  input  logic             lines_valid,
  input  logic [2:0]       lines_count,
  move_scheduler_if.master cmd_if,
  output logic [3:0]       level,
  output logic [15:0]      lines_total,
  output logic [31:0]      gravity_period
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DROP  = 8'h16;
  localparam logic [7:0] KEY_ROT   = 8'h1A;

  // Pend/grant vectors are indexed by the command code they produce.
  localparam int CMD_DOWN  = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_RIGHT = 2;
  localparam int CMD_ROT   = 3;

  localparam logic [1:0] K_IDLE   = 2'd0;
  localparam logic [1:0] K_DELAY  = 2'd1;
  localparam logic [1:0] K_REPEAT = 2'd2;
  localparam logic [1:0] K_HOLD   = 2'd3;

  localparam logic [31:0] BASE_P   = 32'(BASE_PERIOD);
  localparam logic [31:0] MIN_P    = 32'(MIN_PERIOD);
  localparam logic [31:0] DELAY_P  = 32'(DAS_DELAY);
  localparam logic [31:0] REPEAT_P = 32'(DAS_REPEAT);
  localparam logic [15:0] LPL_P    = 16'(LINES_PER_LEVEL);
  localparam logic [3:0]  MAXL_P   = 4'(MAX_LEVEL);

  logic        run;
  logic [31:0] grav_cnt_q, grav_cnt_d, grav_limit;
  logic        grav_fire;
  logic [1:0]  kstate_q, kstate_d;
  logic [7:0]  held_key_q, held_key_d;
  logic [31:0] das_q, das_d;
  logic [3:0]  key_onehot, key_set;
  logic        is_action, new_press;
  logic [3:0]  pend_q, pend_d, set_ev, grant;
  logic        issue;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_q, cmd_d, cmd_code;
  logic [2:0]  add_lines;
  logic [16:0] total_sum;
  logic [15:0] in_sum;
  logic [15:0] in_level_q, in_level_d;
  logic [15:0] lines_total_q, lines_total_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] gravity_period_q, gravity_period_d;
  int          per_calc;

  assign run = enable && !game_over;

  // Gravity counter: soft drop swaps in the short period; a period that
  // shrinks below the current count fires on the next cycle (>= compare).
  always_comb begin
    grav_limit = (keycode == KEY_DROP) ? MIN_P : gravity_period_q;
    grav_fire  = run && (grav_cnt_q >= grav_limit - 32'd1);
    grav_cnt_d = grav_cnt_q;
    if (grav_fire)
      grav_cnt_d = '0;
    else if (run)
      grav_cnt_d = grav_cnt_q + 32'd1;
  end

  // Key FSM: first press, DAS delay, then auto-repeat; rotate never repeats.
  always_comb begin
    kstate_d   = kstate_q;
    held_key_d = held_key_q;
    das_d      = das_q;
    key_set    = '0;
    key_onehot = '0;
    case (keycode)
      KEY_LEFT:  key_onehot[CMD_LEFT]  = 1'b1;
      KEY_RIGHT: key_onehot[CMD_RIGHT] = 1'b1;
      KEY_ROT:   key_onehot[CMD_ROT]   = 1'b1;
      default:   key_onehot            = '0;
    endcase
    is_action = |key_onehot;
    new_press = is_action && (keycode != held_key_q);
    if (run) begin
      held_key_d = keycode;
      if (!is_action) begin
        kstate_d = K_IDLE;
      end else if (new_press) begin
        key_set = key_onehot;
        if (keycode == KEY_ROT) begin
          kstate_d = K_HOLD;
        end else begin
          kstate_d = K_DELAY;
          das_d    = DELAY_P;
        end
      end else if (kstate_q == K_DELAY || kstate_q == K_REPEAT) begin
        if (das_q <= 32'd1) begin
          key_set  = key_onehot;
          das_d    = REPEAT_P;
          kstate_d = K_REPEAT;
        end else begin
          das_d = das_q - 32'd1;
        end
      end
    end
  end

  // Fixed-priority grant: down > rotate > left > right.
  always_comb begin
    grant = '0;
    if (pend_q[CMD_DOWN])       grant[CMD_DOWN]  = 1'b1;
    else if (pend_q[CMD_ROT])   grant[CMD_ROT]   = 1'b1;
    else if (pend_q[CMD_LEFT])  grant[CMD_LEFT]  = 1'b1;
    else if (pend_q[CMD_RIGHT]) grant[CMD_RIGHT] = 1'b1;
    cmd_code = grant[CMD_ROT]   ? 2'd3 :
               grant[CMD_RIGHT] ? 2'd2 :
               grant[CMD_LEFT]  ? 2'd1 : 2'd0;
    issue = run && (|pend_q) && (!cmd_valid_q || cmd_if.cmd_ready);
  end

  assign set_ev = key_set | {3'b000, grav_fire};

  // Single-bit pend flags: a new event beats the grant clear in the same
  // cycle, and everything drops while the scheduler is not running.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_d[gi] = run && (set_ev[gi] || (pend_q[gi] && !(issue && grant[gi])));
    end
  endgenerate

  // Command port: hold the offer until ready, allow back-to-back issue,
  // and withdraw immediately on game_over.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    if (game_over) begin
      cmd_valid_d = 1'b0;
    end else if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_code;
    end else if (cmd_valid_q && cmd_if.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Line accounting: clamp to 4 rows, saturate the total, one level step per pulse.
  always_comb begin
    add_lines     = (lines_count > 3'd4) ? 3'd4 : lines_count;
    total_sum     = {1'b0, lines_total_q} + 17'(add_lines);
    in_sum        = in_level_q + 16'(add_lines);
    lines_total_d = lines_total_q;
    in_level_d    = in_level_q;
    level_d       = level_q;
    if (lines_valid && !game_over && add_lines != 3'd0) begin
      lines_total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      if (in_sum >= LPL_P) begin
        in_level_d = in_sum - LPL_P;
        if (level_q < MAXL_P)
          level_d = level_q + 4'd1;
      end else begin
        in_level_d = in_sum;
      end
    end
  end

  // Gravity period from the registered level; signed math avoids wrap below zero.
  always_comb begin
    per_calc         = BASE_PERIOD - int'(level_q) * PERIOD_STEP;
    gravity_period_d = (per_calc < MIN_PERIOD) ? MIN_P : $unsigned(per_calc);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grav_cnt_q       <= '0;
      kstate_q         <= K_IDLE;
      held_key_q       <= '0;
      das_q            <= '0;
      pend_q           <= '0;
      cmd_valid_q      <= 1'b0;
      cmd_q            <= 2'd0;
      in_level_q       <= '0;
      lines_total_q    <= '0;
      level_q          <= '0;
      gravity_period_q <= BASE_P;
    end else begin
      grav_cnt_q       <= grav_cnt_d;
      kstate_q         <= kstate_d;
      held_key_q       <= held_key_d;
      das_q            <= das_d;
      pend_q           <= pend_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_q            <= cmd_d;
      in_level_q       <= in_level_d;
      lines_total_q    <= lines_total_d;
      level_q          <= level_d;
      gravity_period_q <= gravity_period_d;
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd       = cmd_q;
  assign level            = level_q;
  assign lines_total      = lines_total_q;
  assign gravity_period   = gravity_period_q;

endmodule
